// File: rtl/ll_storage.sv
// Storage back-end for the reassembly linked-list engine: a simple two-port node RAM
// (2-cycle read latency) and a show-ahead ready/valid FIFO used as the free-node list.

module bram_simple2port #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 2**AWIDTH
) (
    input  logic              clk,
    input  logic              wr,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);
    logic [DWIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DWIDTH-1:0] rd_word = '0;
    logic [DWIDTH-1:0] rd_q    = '0;
    logic              rd_r1   = 1'b0;

    // Array is sampled on the read edge itself, so a same-edge write is not seen (read-first).
    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_addr] <= wr_data;
        if (rd)
            rd_word <= mem[rd_addr];
        rd_r1 <= rd;
        if (rd_r1)
            rd_q <= rd_word;
    end

    assign rd_data = rd_q;
endmodule

module fifo_wrapper #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // Asynchronous head read gives next-cycle visibility after a push into an empty FIFO.
    assign out_data  = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (push)
            store[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module ll_storage #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 64,
    parameter int DEPTH      = 2**AWIDTH,
    parameter int FL_WIDTH   = AWIDTH,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_wr,
    input  logic [AWIDTH-1:0]   mem_wr_addr,
    input  logic [DWIDTH-1:0]   mem_wr_data,
    input  logic                mem_rd,
    input  logic [AWIDTH-1:0]   mem_rd_addr,
    output logic [DWIDTH-1:0]   mem_rd_data,
    input  logic [FL_WIDTH-1:0] fl_in_data,
    input  logic                fl_in_valid,
    output logic                fl_in_ready,
    output logic [FL_WIDTH-1:0] fl_out_data,
    output logic                fl_out_valid,
    input  logic                fl_out_ready
);
    // RAM contents and read data survive rst; only the free list is cleared.
    bram_simple2port #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .wr      (mem_wr),
        .wr_addr (mem_wr_addr),
        .wr_data (mem_wr_data),
        .rd      (mem_rd),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    fifo_wrapper #(.WIDTH(FL_WIDTH), .DEPTH(FIFO_DEPTH)) u_fl (
        .clk       (clk),
        .rst       (rst),
        .in_data   (fl_in_data),
        .in_valid  (fl_in_valid),
        .in_ready  (fl_in_ready),
        .out_data  (fl_out_data),
        .out_valid (fl_out_valid),
        .out_ready (fl_out_ready)
    );
endmodule

// File: tb/tb_ll_storage.sv
// Randomized self-checking bench for ll_storage: array model of the node RAM with a timed
// read-result queue, and a queue model of the free-list FIFO.

module tb_ll_storage;
    localparam int AWIDTH     = 9;
    localparam int DWIDTH     = 64;
    localparam int DEPTH      = 512;
    localparam int FL_WIDTH   = 9;
    localparam int FIFO_DEPTH = 512;

    logic                clk = 1'b0;
    logic                rst;
    logic                mem_wr;
    logic [AWIDTH-1:0]   mem_wr_addr;
    logic [DWIDTH-1:0]   mem_wr_data;
    logic                mem_rd;
    logic [AWIDTH-1:0]   mem_rd_addr;
    logic [DWIDTH-1:0]   mem_rd_data;
    logic [FL_WIDTH-1:0] fl_in_data;
    logic                fl_in_valid;
    logic                fl_in_ready;
    logic [FL_WIDTH-1:0] fl_out_data;
    logic                fl_out_valid;
    logic                fl_out_ready;

    ll_storage #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .DEPTH(DEPTH),
                 .FL_WIDTH(FL_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wr       (mem_wr),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd       (mem_rd),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .fl_in_data   (fl_in_data),
        .fl_in_valid  (fl_in_valid),
        .fl_in_ready  (fl_in_ready),
        .fl_out_data  (fl_out_data),
        .fl_out_valid (fl_out_valid),
        .fl_out_ready (fl_out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [DWIDTH-1:0] data;
    } rd_t;

    logic [DWIDTH-1:0]   ram_m [DEPTH];
    rd_t                 rq[$];
    logic [FL_WIDTH-1:0] fq[$];
    logic [DWIDTH-1:0]   exp_rd;
    int                  edges;
    int                  checks;
    int                  errors;

    // Apply this cycle's inputs to the models, clock once, then retire read results that are due.
    task automatic step();
        bit push, pop;
        push = fl_in_valid && (fq.size() < FIFO_DEPTH);
        pop  = fl_out_ready && (fq.size() > 0);
        if (mem_rd) rq.push_back('{edges + 2, ram_m[mem_rd_addr]});
        if (mem_wr) ram_m[mem_wr_addr] = mem_wr_data;
        if (rst) fq.delete();
        else begin
            if (pop)  void'(fq.pop_front());
            if (push) fq.push_back(fl_in_data);
        end
        @(posedge clk);
        #1;
        edges++;
        while (rq.size() > 0 && rq[0].due <= edges) begin
            exp_rd = rq[0].data;
            void'(rq.pop_front());
        end
    endtask

    task automatic idle_inputs();
        mem_wr = 0; mem_rd = 0; fl_in_valid = 0; fl_out_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; step(); step(); rst = 0;
        checks++; if (fl_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fl_out_valid); end
        checks++; if (fl_in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", fl_in_ready); end
        checks++; if (mem_rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", mem_rd_data); end
    endtask

    task automatic test_ram_basic();
        mem_wr = 1; mem_wr_addr = 3; mem_wr_data = 64'hA5; step();
        mem_wr = 0; mem_rd = 1; mem_rd_addr = 3; step();
        mem_rd = 0;
        checks++; if (mem_rd_data !== 64'h0) begin errors++; $display("FAIL ram_latency_early got %h want 0", mem_rd_data); end
        step();
        checks++; if (mem_rd_data !== 64'hA5 || exp_rd !== 64'hA5) begin errors++; $display("FAIL ram_basic got %h want a5", mem_rd_data); end
        step();
        checks++; if (mem_rd_data !== 64'hA5) begin errors++; $display("FAIL ram_hold got %h want a5", mem_rd_data); end
    endtask

    task automatic test_ram_collision();
        mem_rd = 1; mem_rd_addr = 7; step();
        mem_rd = 0; step();
        checks++; if (mem_rd_data !== 64'h0) begin errors++; $display("FAIL ram_unwritten got %h want 0", mem_rd_data); end
        mem_wr = 1; mem_wr_addr = 7; mem_wr_data = 64'h11; mem_rd = 1; step();
        mem_wr = 0; step();
        mem_rd = 0;
        checks++; if (mem_rd_data !== 64'h0) begin errors++; $display("FAIL ram_collision_old got %h want 0", mem_rd_data); end
        step();
        checks++; if (mem_rd_data !== 64'h11) begin errors++; $display("FAIL ram_after_collision got %h want 11", mem_rd_data); end
    endtask

    task automatic test_fifo_fill();
        do_reset();
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            checks++; if (fl_in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b want 1", i, fl_in_ready); end
            fl_in_valid = 1; fl_in_data = FL_WIDTH'(i); step();
        end
        checks++; if (fl_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", fl_in_ready); end
        fl_in_data = 9'h155;
        repeat (3) step();
        fl_in_valid = 0;
        checks++; if (fl_in_ready !== 1'b0 || fl_out_data !== 9'd0) begin errors++; $display("FAIL push_full got ready=%b head=%0d want 0/0", fl_in_ready, fl_out_data); end
        fl_out_ready = 1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            checks++; if (fl_out_valid !== 1'b1 || fl_out_data !== FL_WIDTH'(i)) begin errors++; $display("FAIL drain[%0d] got v=%b d=%0d want 1/%0d", i, fl_out_valid, fl_out_data, i); end
            step();
        end
        fl_out_ready = 0;
        checks++; if (fl_out_valid !== 1'b0 || fl_in_ready !== 1'b1) begin errors++; $display("FAIL drained got v=%b r=%b want 0/1", fl_out_valid, fl_in_ready); end
    endtask

    task automatic test_fifo_pushpop();
        int n;
        logic [FL_WIDTH-1:0] last;
        do_reset();
        fl_in_valid = 1; fl_in_data = 5; step(); fl_in_data = 6; step();
        fl_in_data = 9; fl_out_ready = 1; step();
        fl_in_valid = 0; fl_out_ready = 0;
        checks++; if (fl_out_valid !== 1'b1 || fl_out_data !== 9'd6 || fq.size() != 2) begin errors++; $display("FAIL pushpop_head got %0d want 6", fl_out_data); end
        fl_out_ready = 1; step();
        checks++; if (fl_out_data !== 9'd9) begin errors++; $display("FAIL pushpop_second got %0d want 9", fl_out_data); end
        step(); fl_out_ready = 0;
        checks++; if (fl_out_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty got %b want 0", fl_out_valid); end
        fl_in_valid = 1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin fl_in_data = FL_WIDTH'(i); step(); end
        fl_in_data = 9'h0AB; fl_out_ready = 1; step();
        fl_in_valid = 0; fl_out_ready = 0;
        checks++; if (fl_in_ready !== 1'b1 || fl_out_data !== 9'd1) begin errors++; $display("FAIL full_pushpop got r=%b d=%0d want 1/1", fl_in_ready, fl_out_data); end
        n = 0; last = '0; fl_out_ready = 1;
        while (fl_out_valid === 1'b1 && n < FIFO_DEPTH + 4) begin last = fl_out_data; n++; step(); end
        fl_out_ready = 0;
        checks++; if (n != FIFO_DEPTH - 1 || last !== FL_WIDTH'(FIFO_DEPTH - 1)) begin errors++; $display("FAIL full_pushpop_drain got n=%0d last=%0d want %0d/%0d", n, last, FIFO_DEPTH - 1, FIFO_DEPTH - 1); end
    endtask

    task automatic test_fifo_misuse();
        logic [FL_WIDTH-1:0] v [3];
        do_reset();
        fl_out_ready = 1;
        repeat (3) step();
        fl_out_ready = 0;
        checks++; if (fl_out_valid !== 1'b0 || fl_in_ready !== 1'b1) begin errors++; $display("FAIL pop_empty got v=%b r=%b want 0/1", fl_out_valid, fl_in_ready); end
        fl_in_valid = 1;
        for (int i = 0; i < 3; i++) begin v[i] = FL_WIDTH'($urandom); fl_in_data = v[i]; step(); end
        fl_in_valid = 0; fl_out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (fl_out_valid !== 1'b1 || fl_out_data !== v[i]) begin errors++; $display("FAIL misuse_order[%0d] got %0d want %0d", i, fl_out_data, v[i]); end
            step();
        end
        fl_out_ready = 0;
    endtask

    task automatic test_reset_mid();
        logic [DWIDTH-1:0] held;
        do_reset();
        fl_in_valid = 1;
        for (int i = 0; i < 3; i++) begin fl_in_data = FL_WIDTH'(i + 20); step(); end
        held = mem_rd_data;
        rst = 1; fl_out_ready = 1; step();
        rst = 0; idle_inputs();
        checks++; if (fl_out_valid !== 1'b0 || fl_in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got v=%b r=%b want 0/1", fl_out_valid, fl_in_ready); end
        checks++; if (mem_rd_data !== held) begin errors++; $display("FAIL mid_reset_rd_data got %h want %h", mem_rd_data, held); end
        mem_rd = 1; mem_rd_addr = 3; step(); mem_rd = 0; step();
        checks++; if (mem_rd_data !== 64'hA5) begin errors++; $display("FAIL ram_retained got %h want a5", mem_rd_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            mem_wr       = $urandom_range(0, 1);
            mem_wr_addr  = AWIDTH'($urandom_range(0, 15));
            mem_wr_data  = {$urandom, $urandom};
            mem_rd       = $urandom_range(0, 1);
            mem_rd_addr  = AWIDTH'($urandom_range(0, 15));
            fl_in_valid  = ($urandom_range(0, 9) < ((c < 1500) ? 8 : 3));
            fl_in_data   = FL_WIDTH'($urandom);
            fl_out_ready = ($urandom_range(0, 9) < ((c < 1500) ? 2 : 7));
            step();
            checks++; if (mem_rd_data !== exp_rd) begin errors++; $display("FAIL rnd_ram[%0d] got %h want %h", c, mem_rd_data, exp_rd); end
            checks++; if (fl_out_valid !== (fq.size() > 0) || fl_in_ready !== (fq.size() < FIFO_DEPTH)) begin
                errors++; $display("FAIL rnd_flags[%0d] got v=%b r=%b want count %0d", c, fl_out_valid, fl_in_ready, fq.size());
            end
            if (fq.size() > 0) begin
                checks++; if (fl_out_data !== fq[0]) begin errors++; $display("FAIL rnd_head[%0d] got %0d want %0d", c, fl_out_data, fq[0]); end
            end
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        checks = 0; errors = 0; edges = 0; exp_rd = '0;
        foreach (ram_m[i]) ram_m[i] = '0;
        mem_wr_addr = '0; mem_wr_data = '0; mem_rd_addr = '0; fl_in_data = '0;
        idle_inputs();
        rst = 1;
        test_reset();
        test_ram_basic();
        test_ram_collision();
        test_fifo_fill();
        test_fifo_pushpop();
        test_fifo_misuse();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
